// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of the fetch handshake, register-file read port and
//                ID/EX output bus seen by the RV32I decode stage.
//                "master" is the surrounding pipeline, "slave" is decode.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_stage_if;
   // IF/ID side
   logic        if_valid_i;
   logic [31:0] if_instr_i;
   logic [31:0] if_pc_i;
   logic        id_ready_o;
   // register file read port
   logic [4:0]  rf_read_register_1_o;
   logic [4:0]  rf_read_register_2_o;
   logic [31:0] rf_data_1_i;
   logic [31:0] rf_data_2_i;
   // EX side control
   logic        ex_ready_i;
   logic        flush_i;
   // ID/EX register contents
   logic        ex_valid_o;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_rs1_data_o;
   logic [31:0] ex_rs2_data_o;
   logic [4:0]  ex_rs1_o;
   logic [4:0]  ex_rs2_o;
   logic [4:0]  ex_rd_o;
   logic [31:0] ex_imm_o;
   logic [6:0]  ex_opcode_o;
   logic [2:0]  ex_funct3_o;
   logic [6:0]  ex_funct7_o;
   logic        ex_is_load_o;
   logic        ex_illegal_o;

   modport master (
      output if_valid_i, if_instr_i, if_pc_i,
      input  id_ready_o,
      input  rf_read_register_1_o, rf_read_register_2_o,
      output rf_data_1_i, rf_data_2_i,
      output ex_ready_i, flush_i,
      input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
      input  ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o,
      input  ex_opcode_o, ex_funct3_o, ex_funct7_o, ex_is_load_o, ex_illegal_o
   );

   modport slave (
      input  if_valid_i, if_instr_i, if_pc_i,
      output id_ready_o,
      output rf_read_register_1_o, rf_read_register_2_o,
      input  rf_data_1_i, rf_data_2_i,
      input  ex_ready_i, flush_i,
      output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
      output ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o,
      output ex_opcode_o, ex_funct3_o, ex_funct7_o, ex_is_load_o, ex_illegal_o
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I instruction decode. Splits the IF/ID instruction into
//                fields, drives register-file read addresses, builds the
//                immediate, inserts a one-cycle bubble on load-use hazards and
//                owns the ID/EX pipeline register (stall / bubble / flush).
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage #(
   parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
   parameter int          REG_ADDR_BITS = 5
) (
   input  logic           clk_i,
   input  logic           reset_i,
   decode_stage_if.slave  bus
);

   localparam logic [6:0] c_opc_lui      = 7'b0110111;
   localparam logic [6:0] c_opc_auipc    = 7'b0010111;
   localparam logic [6:0] c_opc_jal      = 7'b1101111;
   localparam logic [6:0] c_opc_jalr     = 7'b1100111;
   localparam logic [6:0] c_opc_branch   = 7'b1100011;
   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_store    = 7'b0100011;
   localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
   localparam logic [6:0] c_opc_op       = 7'b0110011;
   localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
   localparam logic [6:0] c_opc_system   = 7'b1110011;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        is_load;
      logic        illegal;
   } id_ex_t;

   id_ex_t      ex_q, ex_d;

   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic        w_fmt_r, w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_u, w_fmt_j;
   logic        w_fence;
   logic        w_legal;
   logic        w_rs1_used, w_rs2_used, w_rd_used;
   logic [31:0] w_imm;
   logic        w_rs1_hit, w_rs2_hit;
   logic        w_hazard;

   assign w_instr  = bus.if_instr_i;
   assign w_opcode = w_instr[6:0];

   // Register-file addresses come straight from the instruction, valid or not
   assign bus.rf_read_register_1_o = w_instr[19:15];
   assign bus.rf_read_register_2_o = w_instr[24:20];

   // Classify the opcode into its immediate/register format
   always_comb begin
      w_fmt_r = 1'b0;
      w_fmt_i = 1'b0;
      w_fmt_s = 1'b0;
      w_fmt_b = 1'b0;
      w_fmt_u = 1'b0;
      w_fmt_j = 1'b0;
      w_fence = 1'b0;
      case (w_opcode)
         c_opc_op:                                        w_fmt_r = 1'b1;
         c_opc_op_imm, c_opc_load, c_opc_jalr, c_opc_system: w_fmt_i = 1'b1;
         c_opc_store:                                     w_fmt_s = 1'b1;
         c_opc_branch:                                    w_fmt_b = 1'b1;
         c_opc_lui, c_opc_auipc:                          w_fmt_u = 1'b1;
         c_opc_jal:                                       w_fmt_j = 1'b1;
         // FENCE is legal but uses no registers or immediate here
         c_opc_misc_mem:                                  w_fence = 1'b1;
         default: ;
      endcase
   end

   assign w_legal    = w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b | w_fmt_u | w_fmt_j | w_fence;
   assign w_rs1_used = w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b;
   assign w_rs2_used = w_fmt_r | w_fmt_s | w_fmt_b;
   assign w_rd_used  = w_fmt_r | w_fmt_i | w_fmt_u | w_fmt_j;

   // Build the sign-extended immediate for the decoded format
   always_comb begin
      w_imm = 32'h0;
      if (w_fmt_i) begin
         w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      end else if (w_fmt_s) begin
         w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end else if (w_fmt_b) begin
         w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                  w_instr[11:8], 1'b0};
      end else if (w_fmt_u) begin
         w_imm = {w_instr[31:12], 12'h000};
      end else if (w_fmt_j) begin
         w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                  w_instr[30:21], 1'b0};
      end
   end

   // Load-use: only the low REG_ADDR_BITS of the indices are significant
   assign w_rs1_hit = w_rs1_used &
                      (w_instr[15 +: REG_ADDR_BITS] == ex_q.rd[REG_ADDR_BITS-1:0]);
   assign w_rs2_hit = w_rs2_used &
                      (w_instr[20 +: REG_ADDR_BITS] == ex_q.rd[REG_ADDR_BITS-1:0]);
   assign w_hazard  = ex_q.valid & ex_q.is_load &
                      (ex_q.rd[REG_ADDR_BITS-1:0] != '0) &
                      bus.if_valid_i & (w_rs1_hit | w_rs2_hit);

   // A flush always consumes the IF/ID entry; otherwise accept only if EX moves
   assign bus.id_ready_o = bus.flush_i | (bus.ex_ready_i & ~w_hazard);

   // Next ID/EX contents: flush > EX stall > load-use bubble > issue > empty
   always_comb begin
      ex_d = ex_q;
      if (bus.flush_i) begin
         ex_d.valid = 1'b0;
      end else if (!bus.ex_ready_i) begin
         ex_d = ex_q;
      end else if (w_hazard) begin
         ex_d.valid = 1'b0;
      end else if (bus.if_valid_i && (w_instr != NOP_INSTR)) begin
         ex_d.valid    = 1'b1;
         ex_d.pc       = bus.if_pc_i;
         ex_d.rs1_data = bus.rf_data_1_i;
         ex_d.rs2_data = bus.rf_data_2_i;
         ex_d.imm      = w_imm;
         ex_d.rs1      = w_rs1_used ? w_instr[19:15] : 5'd0;
         ex_d.rs2      = w_rs2_used ? w_instr[24:20] : 5'd0;
         ex_d.rd       = w_rd_used  ? w_instr[11:7]  : 5'd0;
         ex_d.opcode   = w_opcode;
         ex_d.funct3   = w_instr[14:12];
         ex_d.funct7   = w_instr[31:25];
         ex_d.is_load  = (w_opcode == c_opc_load);
         ex_d.illegal  = ~w_legal;
      end else begin
         ex_d.valid = 1'b0;
      end
   end

   // ID/EX pipeline register with synchronous clear
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.ex_valid_o    = ex_q.valid;
   assign bus.ex_pc_o       = ex_q.pc;
   assign bus.ex_rs1_data_o = ex_q.rs1_data;
   assign bus.ex_rs2_data_o = ex_q.rs2_data;
   assign bus.ex_rs1_o      = ex_q.rs1;
   assign bus.ex_rs2_o      = ex_q.rs2;
   assign bus.ex_rd_o       = ex_q.rd;
   assign bus.ex_imm_o      = ex_q.imm;
   assign bus.ex_opcode_o   = ex_q.opcode;
   assign bus.ex_funct3_o   = ex_q.funct3;
   assign bus.ex_funct7_o   = ex_q.funct7;
   assign bus.ex_is_load_o  = ex_q.is_load;
   assign bus.ex_illegal_o  = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Scoreboard bench for decode_stage. Expected ID/EX contents
//                are pushed when an instruction is driven and popped after
//                the following clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ld;
      logic        ill;
   } ex_t;

   typedef struct packed {
      logic vonly;   // bubble: only ex_valid_o is meaningful
      ex_t  v;
   } sb_t;

   localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
   localparam logic [31:0] BEQ_M4      = 32'hFE00_0EE3;
   localparam logic [31:0] SW_X2_8_X1  = 32'h0020_A423;
   localparam logic [31:0] LUI_X5_1    = 32'h0000_12B7;
   localparam logic [31:0] JAL_X1_M8   = 32'hFF9F_F0EF;
   localparam logic [31:0] ADD_X6_X5X2 = 32'h0022_8333;
   localparam logic [31:0] SUB_X7_X1X3 = 32'h4030_83B3;
   localparam logic [31:0] ILLEGAL     = 32'h0000_007F;
   localparam logic [31:0] LW_X5_X1    = 32'h0000_A283;
   localparam logic [31:0] LW_X5_X5    = 32'h0002_A283;
   localparam logic [31:0] LW_X0_X1    = 32'h0000_A003;
   localparam logic [31:0] ADD_X6_X0X0 = 32'h0000_0333;
   localparam logic [31:0] NOP         = 32'h0000_0013;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   sb_t  sbq[$];

   decode_stage_if bus();

   decode_stage #(
      .NOP_INSTR     (32'h0000_0013),
      .REG_ADDR_BITS (5)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference decode of one instruction
   function automatic ex_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] d1, input logic [31:0] d2);
      ex_t m;
      logic r, i, s, b, u, j, fen;
      logic signed [31:0] si;
      m = '0;
      si = ins;
      {r, i, s, b, u, j, fen} = 7'b0;
      case (ins[6:0])
         7'h33:                      r   = 1'b1;
         7'h13, 7'h03, 7'h67, 7'h73: i   = 1'b1;
         7'h23:                      s   = 1'b1;
         7'h63:                      b   = 1'b1;
         7'h37, 7'h17:               u   = 1'b1;
         7'h6F:                      j   = 1'b1;
         7'h0F:                      fen = 1'b1;
         default: ;
      endcase
      m.valid = 1'b1;
      m.pc    = pc;
      m.d1    = d1;
      m.d2    = d2;
      m.opc   = ins[6:0];
      m.f3    = ins[14:12];
      m.f7    = ins[31:25];
      m.ld    = (ins[6:0] == 7'h03);
      m.ill   = !(r | i | s | b | u | j | fen);
      if (r | i | s | b) m.rs1 = ins[19:15];
      if (r | s | b)     m.rs2 = ins[24:20];
      if (r | i | u | j) m.rd  = ins[11:7];
      if (i) m.imm = si >>> 20;
      if (s) m.imm = ((si >>> 20) & ~32'h1F) | 32'(ins[11:7]);
      if (b) m.imm = (ins[31] ? 32'hFFFF_F000 : 32'h0) | (32'(ins[7]) << 11) |
                     (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      if (u) m.imm = ins & 32'hFFFF_F000;
      if (j) m.imm = (ins[31] ? 32'hFFF0_0000 : 32'h0) | (32'(ins[19:12]) << 12) |
                     (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      return m;
   endfunction

   function automatic ex_t sample();
      ex_t o;
      o.valid = bus.ex_valid_o;
      o.pc    = bus.ex_pc_o;
      o.d1    = bus.ex_rs1_data_o;
      o.d2    = bus.ex_rs2_data_o;
      o.imm   = bus.ex_imm_o;
      o.rs1   = bus.ex_rs1_o;
      o.rs2   = bus.ex_rs2_o;
      o.rd    = bus.ex_rd_o;
      o.opc   = bus.ex_opcode_o;
      o.f3    = bus.ex_funct3_o;
      o.f7    = bus.ex_funct7_o;
      o.ld    = bus.ex_is_load_o;
      o.ill   = bus.ex_illegal_o;
      return o;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
      bus.if_valid_i  = v;
      bus.if_instr_i  = ins;
      bus.if_pc_i     = pc;
      bus.rf_data_1_i = d1;
      bus.rf_data_2_i = d2;
   endtask

   task automatic push_full(input ex_t e);
      sb_t x;
      x.vonly = 1'b0;
      x.v     = e;
      sbq.push_back(x);
   endtask

   task automatic push_bubble();
      sb_t x;
      x.vonly = 1'b1;
      x.v     = '0;
      sbq.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      sb_t e;
      ex_t o;
      rst = 1'b1;
      bus.ex_ready_i = 1'b1;
      bus.flush_i    = 1'b0;
      drive(1'b1, ADDI_X1_5, 32'h40, 32'h1, 32'h2);
      step();
      step();
      push_full('0);
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o !== e.v) begin
         bad++;
         $display("FAIL reset_state: got %h required %h", o, e.v);
      end
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      total++;
      if (bus.id_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_id_ready: got %b required 1", bus.id_ready_o);
      end
      push_bubble();
      step();
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o.valid !== e.v.valid) begin
         bad++;
         $display("FAIL reset_release_valid: got %b required %b", o.valid, e.v.valid);
      end
      total++;
      if (bus.ex_imm_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_release_imm: got %h required 00000000", bus.ex_imm_o);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_immediates();
      logic [31:0] prog [8];
      sb_t e;
      ex_t o;
      logic [31:0] d1, d2, pc;
      prog = '{ADDI_X1_5, BEQ_M4, SW_X2_8_X1, LUI_X5_1,
               JAL_X1_M8, ADD_X6_X5X2, SUB_X7_X1X3, ILLEGAL};
      for (int i = 0; i < 8; i++) begin
         pc = 32'h1000 + 32'(i) * 4;
         d1 = (i == 0) ? 32'h0 : $urandom;
         d2 = $urandom;
         drive(1'b1, prog[i], pc, d1, d2);
         #1;
         total++;
         if (bus.rf_read_register_1_o !== prog[i][19:15] ||
             bus.rf_read_register_2_o !== prog[i][24:20]) begin
            bad++;
            $display("FAIL imm_rf_addr[%0d]: got %0d/%0d required %0d/%0d", i,
                     bus.rf_read_register_1_o, bus.rf_read_register_2_o,
                     prog[i][19:15], prog[i][24:20]);
         end
         push_full(model(prog[i], pc, d1, d2));
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL imm_decode[%0d]: got %h required %h", i, o, e.v);
         end
         if (i == 0) begin
            total++;
            if (o.valid !== 1'b1 || o.rd !== 5'd1 || o.imm !== 32'd5 || o.rs2 !== 5'd0) begin
               bad++;
               $display("FAIL imm_addi: got v=%b rd=%0d imm=%h rs2=%0d required v=1 rd=1 imm=5 rs2=0",
                        o.valid, o.rd, o.imm, o.rs2);
            end
         end
         if (i == 1) begin
            total++;
            if (o.imm !== 32'hFFFF_FFFC || o.rd !== 5'd0) begin
               bad++;
               $display("FAIL imm_beq: got imm=%h rd=%0d required imm=fffffffc rd=0", o.imm, o.rd);
            end
         end
         if (i == 7) begin
            total++;
            if (o.valid !== 1'b1 || o.ill !== 1'b1) begin
               bad++;
               $display("FAIL imm_illegal: got v=%b ill=%b required v=1 ill=1", o.valid, o.ill);
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_load_use();
      logic [31:0] prog [2];
      logic        bub  [2];
      sb_t e;
      ex_t o;
      prog = '{LW_X5_X1, ADD_X6_X5X2};
      bub  = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         if (bub[i]) begin
            drive(1'b1, prog[i], 32'h2004, 32'h11, 32'h22);
            #1;
            total++;
            if (bus.id_ready_o !== 1'b0) begin
               bad++;
               $display("FAIL lu_ready_low[%0d]: got %b required 0", i, bus.id_ready_o);
            end
            push_bubble();
            step();
            e = sbq.pop_front();
            o = sample();
            total++;
            if (o.valid !== e.v.valid) begin
               bad++;
               $display("FAIL lu_bubble[%0d]: got %b required %b", i, o.valid, e.v.valid);
            end
         end
         drive(1'b1, prog[i], 32'h2000 + 32'(i) * 4, 32'hBEEF_0000 + 32'(i), 32'h22);
         #1;
         total++;
         if (bus.id_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL lu_ready_high[%0d]: got %b required 1", i, bus.id_ready_o);
         end
         push_full(model(prog[i], 32'h2000 + 32'(i) * 4, 32'hBEEF_0000 + 32'(i), 32'h22));
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL lu_issue[%0d]: got %h required %h", i, o, e.v);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_no_false_hazard();
      logic [31:0] prog [4];
      sb_t e;
      ex_t o;
      prog = '{LW_X0_X1, ADD_X6_X0X0, LW_X5_X1, LUI_X5_1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, prog[i], 32'h3000 + 32'(i) * 4, $urandom, $urandom);
         #1;
         total++;
         if (bus.id_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL nfh_ready[%0d]: got %b required 1", i, bus.id_ready_o);
         end
         push_full(model(prog[i], bus.if_pc_i, bus.rf_data_1_i, bus.rf_data_2_i));
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL nfh_issue[%0d]: got %h required %h", i, o, e.v);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [31:0] prog [3];
      logic        bub  [3];
      sb_t e;
      ex_t o;
      prog = '{LW_X5_X1, LW_X5_X5, ADD_X6_X5X2};
      bub  = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         if (bub[i]) begin
            drive(1'b1, prog[i], 32'h4000 + 32'(i) * 4, 32'h0, 32'h0);
            #1;
            total++;
            if (bus.id_ready_o !== 1'b0) begin
               bad++;
               $display("FAIL b2b_ready_low[%0d]: got %b required 0", i, bus.id_ready_o);
            end
            push_bubble();
            step();
            e = sbq.pop_front();
            o = sample();
            total++;
            if (o.valid !== e.v.valid) begin
               bad++;
               $display("FAIL b2b_bubble[%0d]: got %b required %b", i, o.valid, e.v.valid);
            end
         end
         drive(1'b1, prog[i], 32'h4000 + 32'(i) * 4, $urandom, $urandom);
         #1;
         total++;
         if (bus.id_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_high[%0d]: got %b required 1", i, bus.id_ready_o);
         end
         push_full(model(prog[i], bus.if_pc_i, bus.rf_data_1_i, bus.rf_data_2_i));
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL b2b_issue[%0d]: got %h required %h", i, o, e.v);
         end
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_ex_stall();
      sb_t e;
      ex_t o;
      ex_t held;
      held = model(ADDI_X1_5, 32'h5000, 32'h77, 32'h88);
      drive(1'b1, ADDI_X1_5, 32'h5000, 32'h77, 32'h88);
      push_full(held);
      step();
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o !== e.v) begin
         bad++;
         $display("FAIL stall_first: got %h required %h", o, e.v);
      end
      bus.ex_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, SUB_X7_X1X3, 32'h5004, $urandom, $urandom);
         #1;
         total++;
         if (bus.id_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready[%0d]: got %b required 0", k, bus.id_ready_o);
         end
         push_full(held);
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got %h required %h", k, o, e.v);
         end
      end
      bus.ex_ready_i = 1'b1;
      drive(1'b1, SUB_X7_X1X3, 32'h5004, 32'h123, 32'h456);
      #1;
      total++;
      if (bus.id_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL stall_resume_ready: got %b required 1", bus.id_ready_o);
      end
      push_full(model(SUB_X7_X1X3, 32'h5004, 32'h123, 32'h456));
      step();
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o !== e.v) begin
         bad++;
         $display("FAIL stall_resume: got %h required %h", o, e.v);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_flush();
      sb_t e;
      ex_t o;
      // scenario 0: flush with a live hazard; 1: flush while EX stalls
      for (int s = 0; s < 2; s++) begin
         drive(1'b1, LW_X5_X1, 32'h6000, 32'h10, 32'h20);
         push_full(model(LW_X5_X1, 32'h6000, 32'h10, 32'h20));
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o !== e.v) begin
            bad++;
            $display("FAIL flush_load[%0d]: got %h required %h", s, o, e.v);
         end
         bus.flush_i    = 1'b1;
         bus.ex_ready_i = (s == 0);
         drive(1'b1, ADD_X6_X5X2, 32'h6004, 32'h1, 32'h2);
         #1;
         total++;
         if (bus.id_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_ready[%0d]: got %b required 1", s, bus.id_ready_o);
         end
         push_bubble();
         step();
         e = sbq.pop_front();
         o = sample();
         total++;
         if (o.valid !== e.v.valid) begin
            bad++;
            $display("FAIL flush_valid[%0d]: got %b required %b", s, o.valid, e.v.valid);
         end
         bus.flush_i    = 1'b0;
         bus.ex_ready_i = 1'b1;
      end
      // NOP encoding is a bubble
      drive(1'b1, NOP, 32'h6010, 32'h5, 32'h6);
      push_bubble();
      step();
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o.valid !== e.v.valid) begin
         bad++;
         $display("FAIL nop_bubble: got %b required %b", o.valid, e.v.valid);
      end
      // reset during a hazard clears everything
      drive(1'b1, LW_X5_X1, 32'h6020, 32'h10, 32'h20);
      step();
      drive(1'b1, ADD_X6_X5X2, 32'h6024, 32'h1, 32'h2);
      rst = 1'b1;
      push_full('0);
      step();
      e = sbq.pop_front();
      o = sample();
      total++;
      if (o !== e.v) begin
         bad++;
         $display("FAIL reset_in_hazard: got %h required %h", o, e.v);
      end
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.ex_ready_i = 1'b1;
      bus.flush_i    = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_immediates();
      test_load_use();
      test_no_false_hazard();
      test_back_to_back();
      test_ex_stall();
      test_flush();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID latch and the register file / EX stage.
- Splits the fetched instruction into fields and drives the register-file read addresses.
- Generates the immediate, detects load-use hazards, and owns the ID/EX pipeline register with stall, bubble and flush control.
- Write-back-to-read bypass is done inside the register file. EX/MEM forwarding is done downstream. This block only adds the one-cycle load-use bubble.

Parameters:
- NOP_INSTR, 32'h00000013, encoding treated as a bubble (addi x0,x0,0); a bubble drives ex_valid_o=0.
- REG_ADDR_BITS, 5, register index width. Set to 4 for RV32E; upper rs/rd bits are then ignored in hazard compares.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- if_valid_i  in  1  IF/ID holds a valid instruction
- if_instr_i  in  32  instruction word
- if_pc_i  in  32  instruction PC
- id_ready_o  out  1  decode accepts if_instr_i this cycle (0 = fetch holds)
- rf_read_register_1_o  out  5  rs1 index to register file (instr[19:15])
- rf_read_register_2_o  out  5  rs2 index to register file (instr[24:20])
- rf_data_1_i  in  32  rs1 data (combinational return, WB-bypassed)
- rf_data_2_i  in  32  rs2 data
- ex_ready_i  in  1  EX can accept a new instruction
- flush_i  in  1  branch/jump redirect from EX; kill the instruction in decode
- ex_valid_o  out  1  ID/EX entry valid
- ex_pc_o  out  32  latched PC
- ex_rs1_data_o, ex_rs2_data_o  out  32 each  latched operands
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  latched register indices (0 if unused by format)
- ex_imm_o  out  32  sign-extended immediate
- ex_opcode_o  out  7;  ex_funct3_o  out  3;  ex_funct7_o  out  7
- ex_is_load_o  out  1  opcode == 7'b0000011
- ex_illegal_o  out  1  opcode not in RV32I base set

Behaviour:
- Reset: all ex_* outputs are 0, including ex_valid_o. id_ready_o follows its combinational rule. Reset overrides every other input on that edge.
- rf_read_register_*_o are combinational from if_instr_i regardless of valid. Operands are captured in the same cycle they are read, so decode latency is 1 cycle (IF/ID to ID/EX).
- Immediate formats:
  - I: OP-IMM, LOAD, JALR, SYSTEM
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - R-type: imm = 0
  - All immediates sign-extend from instr[31].
- Register use:
  - rs1 used by R, I, S, B formats.
  - rs2 used by R, S, B formats.
  - rd written by R, I, U, J formats.
  - An unused index is latched as 0.
- Load-use hazard: `hazard = ex_valid_o & ex_is_load_o & ex_rd_o!=0 & if_valid_i & ((rs1 used & rs1==ex_rd_o) | (rs2 used & rs2==ex_rd_o))`. Compare only the low REG_ADDR_BITS bits.
- id_ready_o = flush_i | (ex_ready_i & ~hazard).
- Per-edge priority:
  1. reset_i: clear the ID/EX register.
  2. flush_i: ex_valid_o<=0. The instruction in IF/ID is consumed and discarded (id_ready_o=1).
  3. ~ex_ready_i: hold all ex_* unchanged.
  4. hazard: ex_valid_o<=0 (bubble); IF/ID is held; the instruction re-decodes next cycle with WB-bypassed data.
  5. if_valid_i and instr != NOP_INSTR: load all fields, ex_valid_o<=1.
  6. Otherwise: ex_valid_o<=0. Other ex_* fields may update but are don't-care.
- Flush and hazard in the same cycle: flush wins, and no bubble is counted.
- Back-to-back loads to the same rd each produce exactly one bubble per dependent consumer.
- Illegal opcode: passed down with ex_illegal_o=1 and ex_valid_o=1. Trap handling is downstream.
- Reset asserted during a hazard or stall clears ex_valid_o. The state of IF/ID is the fetch stage's responsibility.

Test Plan:
- Reset: hold reset_i 2 cycles, then release with if_valid_i=0 -> ex_valid_o=0, ex_imm_o=0, id_ready_o=1.
- Immediates:
  - 0x00500093 (addi x1,x0,5), rf_data_1_i=0 -> next edge ex_valid_o=1, ex_rd_o=1, ex_imm_o=5, ex_rs2_o=0.
  - 0xFE000EE3 (beq x0,x0,-4) -> ex_imm_o=0xFFFFFFFC, ex_rd_o=0.
- Load-use: lw x5,0(x1), then add x6,x5,x2 -> on the add's first decode cycle, id_ready_o=0. The next edge emits a bubble (ex_valid_o=0). The add issues one cycle later with rf_data_1_i sampled then.
- No false hazard: lw x0,0(x1), then add x6,x0,x0 -> no bubble. Also lw x5, then lui x5,1 -> no bubble.
- EX stall: ex_ready_i=0 for 3 cycles with a valid instruction in ID/EX -> all ex_* unchanged and id_ready_o=0 throughout. Normal flow resumes the cycle after ex_ready_i=1.
- Flush during hazard: hazard condition present and flush_i=1 -> id_ready_o=1 and ex_valid_o=0 next edge. A NOP_INSTR input also yields ex_valid_o=0.
